// File: rtl/addr_arb_pkg.sv
// Shared types and constants for the N-channel address arbiter.
// Holds the state encoding, arbitration mode codes and the channel-index width helper.
package addr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int ch_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_arbiter_rr_pick.sv
// One-hot request picker searching upward from a rotating start index, wrapping at NUM_CH-1.
// Purely combinational; a start of 0 gives plain lowest-index priority.
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   start,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   idx
);

    logic            found;
    logic [CH_W:0]   cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            // One extra bit so start+k cannot overflow before the wrap.
            cand = {1'b0, start} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!found && req[cand[CH_W-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[CH_W-1:0]]   = 1'b1;
                idx                   = cand[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/addr_arbiter.sv
// Registered N-channel address arbiter: grant is combinational, address/channel/valid appear one cycle later.
// Holds the captured address until mux_ready; no grants while held, back-to-back capture on accept.
module addr_arbiter
    import addr_arb_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 5,
    parameter  int NUM_CH        = 2,
    parameter  int MODE          = 0,
    localparam int CH_W          = ch_width(NUM_CH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               req,
    input  logic [NUM_CH*ADDRESS_WIDTH-1:0] add_in,
    output logic [NUM_CH-1:0]               grant,
    output logic [ADDRESS_WIDTH-1:0]        mux_add,
    output logic [CH_W-1:0]                 mux_ch,
    output logic                            mux_valid,
    input  logic                            mux_ready
);

    arb_state_e              state_q, state_d;
    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] add_q, add_d;
    logic [CH_W-1:0]         ch_q, ch_d;

    logic [CH_W-1:0]         pick_start;
    logic [NUM_CH-1:0]       pick_gnt;
    logic [CH_W-1:0]         pick_idx;
    logic [ADDRESS_WIDTH-1:0] sel_add;
    logic                    load;
    logic                    capture;

    assign pick_start = (MODE == ARB_RR) ? rr_ptr_q : '0;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req    (req),
        .start  (pick_start),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    assign load    = (state_q == ST_IDLE) || mux_ready;
    assign capture = load && (|req);
    assign grant   = (capture && !rst) ? pick_gnt : '0;

    // One-hot AND-OR mux keeps add_in off every combinational output path.
    always_comb begin
        sel_add = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick_gnt[i]) begin
                sel_add = sel_add | add_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        add_d    = add_q;
        ch_d     = ch_q;
        if (capture) begin
            state_d = ST_HOLD;
            add_d   = sel_add;
            ch_d    = pick_idx;
            if (MODE == ARB_RR) begin
                rr_ptr_d = (pick_idx == CH_W'(NUM_CH-1)) ? '0 : pick_idx + 1'b1;
            end
        end else if (load) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            add_q    <= '0;
            ch_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            add_q    <= add_d;
            ch_q     <= ch_d;
        end
    end

    assign mux_add   = add_q;
    assign mux_ch    = ch_q;
    assign mux_valid = (state_q == ST_HOLD);

endmodule

// File: doc/addr_arbiter.md
# addr_arbiter

Registered, parametrised N-channel address arbiter. It is the successor to the CPU's 2:1 instruction/operand address mux. Up to NUM_CH requesters (instruction fetch, operand fetch, future DMA/debug ports) compete for one memory address port. The block adds per-channel request/grant handshakes, fixed-priority or round-robin arbitration, and a valid/ready output that holds the address until memory accepts it. It sits between the control unit's address sources and the memory address input.

## Interface
Parameters:
- ADDRESS_WIDTH, 5, width of every address.
- NUM_CH, 2, number of requesting channels; legal range 2..16.
- MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round robin.

Derived:
- CH_W = max(1, $clog2(NUM_CH)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  NUM_CH  per-channel request; bit i asserted means add_in slice i is valid.
- add_in  in  NUM_CH*ADDRESS_WIDTH  packed channel addresses; channel i occupies bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- grant  out  NUM_CH  one-hot, combinational; bit i high means channel i's address is captured at this edge.
- mux_add  out  ADDRESS_WIDTH  registered selected address.
- mux_ch  out  CH_W  registered index of the channel that owns mux_add.
- mux_valid  out  1  registered; mux_add/mux_ch hold a pending transfer.
- mux_ready  in  1  memory accepts the transfer when mux_valid && mux_ready.

## Operation
- Two states:
  - IDLE: mux_valid=0.
  - HOLD: mux_valid=1, waiting for mux_ready.
- load = (state==IDLE) || mux_ready. Capture happens when load && |req.
- Winner selection:
  - MODE 0: lowest-index asserted req.
  - MODE 1: first asserted req searching upward from rr_ptr, wrapping NUM_CH-1 -> 0.
- On capture:
  - mux_add <= add_in[winner]; mux_ch <= winner; mux_valid <= 1; state -> HOLD.
  - grant[winner]=1 in that cycle.
  - MODE 1: rr_ptr <= (winner+1) mod NUM_CH.
- Transitions:
  - IDLE, req==0 -> stay IDLE.
  - HOLD, mux_ready=0 -> stay HOLD. mux_add, mux_ch and mux_valid stay stable; grant=0 even if higher-priority req arrives.
  - HOLD, mux_ready=1, |req -> HOLD with the new capture (back-to-back, one transfer per cycle).
  - HOLD, mux_ready=1, req==0 -> IDLE; mux_valid <= 0; mux_add/mux_ch keep their last value.
- Requester rule:
  - Keep req and add_in stable until its grant bit is seen high at a clock edge.
  - After that edge, either drop req or present its next address.
  - Channels are never granted twice for one request.
- rr_ptr changes only on capture. It is unused (held 0) in MODE 0.

## Timing
- Reset (rst=1 at edge): mux_add=0, mux_ch=0, mux_valid=0, rr_ptr=0, state=IDLE. grant is forced to 0 while rst=1.
- Reset mid-transfer: the pending address is discarded; no grant, no acceptance.
- Latency: req rising in cycle n with the block idle gives grant in cycle n and mux_valid/mux_add in cycle n+1.
- Throughput: one address per cycle while mux_ready stays 1 and requests are present.
- Combinational paths:
  - grant depends on req, state, mux_ready, rr_ptr only.
  - No path from add_in to any output except through the mux_add register.
- Simultaneous accept and new request: handled by the back-to-back rule. There is no idle bubble.

## Structure
- Shared package addr_arb_pkg:
  - state enum {ST_IDLE, ST_HOLD}.
  - MODE constants ARB_FIXED=0, ARB_RR=1.
- Sub-module rr_pick:
  - Parametrised NUM_CH one-hot picker with a rotating start index (MODE 0 ties start to 0).
  - Outputs a one-hot winner and its encoded index.
  - Instantiated once.
- Top module holds the state register, rr_ptr, the output registers and the add_in slice mux.

## Test plan
- Reset, then NUM_CH=2, MODE 0: req=2'b11, add_in={5'd9,5'd4}, mux_ready=1 -> grant=01, next cycle mux_add=4, mux_ch=0, mux_valid=1. Channel 0 then drops req -> grant=10, then mux_add=9, mux_ch=1.
- Backpressure: mux_ready=0 for 3 cycles after capture of address 7 -> mux_add stays 7, grant=0 throughout. mux_ready=1 -> next request is captured on that edge.
- MODE 1, NUM_CH=4, all req held high with addresses 1,2,3,4, mux_ready=1 -> grant sequence 0001,0010,0100,1000,0001; mux_add 1,2,3,4,1 on consecutive cycles.
- Drain: single request granted, req dropped, mux_ready=1 -> mux_valid falls the cycle after acceptance; mux_add keeps its value; state returns to IDLE.
- Reset mid-HOLD with mux_ready=0 and req pending -> next cycle mux_valid=0, mux_add=0, mux_ch=0, grant=0; rr_ptr=0 (first grant after reset goes to channel 0 in MODE 1).
- Random req/mux_ready for 10k cycles against a reference model. Checks:
  - grant is always one-hot or zero.
  - Outputs are stable while mux_valid && !mux_ready.
  - No channel starves in MODE 1 (wait ≤ NUM_CH grants).
